// File: rtl/cell_pos_pkg.sv
// cell_pos_pkg: shared position layout and swap FSM encoding for the ping-pong position store
package cell_pos_pkg;
  localparam int POS_WIDTH = 32;
  localparam int POS_X_LSB = 0;
  localparam int POS_Y_LSB = POS_WIDTH;
  localparam int POS_Z_LSB = 2 * POS_WIDTH;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SWAP, ST_DONE} state_e;
endpackage

// File: rtl/cell_pos_pingpong_if.sv
// cell_pos_pingpong_if: read, append and swap signals of the ping-pong position store
// CELL_POS_OVERFLOW_EN adds the overflow flag and counter.
interface cell_pos_pingpong_if
  import cell_pos_pkg::*;
#(
  parameter int DATA_WIDTH = 3 * POS_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [CNT_WIDTH-1:0]  rd_count;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic [CNT_WIDTH-1:0]  wr_count;
  logic                  swap_req;
  logic                  swap_busy;
  logic                  swap_done;
  logic                  rd_bank;
`ifdef CELL_POS_OVERFLOW_EN
  logic                  ovf_flag;
  logic [15:0]           ovf_cnt;
  modport master (output rd_en, rd_addr, wr_valid, wr_data, swap_req,
                  input rd_data, rd_valid, rd_count, wr_ready, wr_count, swap_busy, swap_done, rd_bank, ovf_flag, ovf_cnt);
  modport slave  (input rd_en, rd_addr, wr_valid, wr_data, swap_req,
                  output rd_data, rd_valid, rd_count, wr_ready, wr_count, swap_busy, swap_done, rd_bank, ovf_flag, ovf_cnt);
`else
  modport master (output rd_en, rd_addr, wr_valid, wr_data, swap_req,
                  input rd_data, rd_valid, rd_count, wr_ready, wr_count, swap_busy, swap_done, rd_bank);
  modport slave  (input rd_en, rd_addr, wr_valid, wr_data, swap_req,
                  output rd_data, rd_valid, rd_count, wr_ready, wr_count, swap_busy, swap_done, rd_bank);
`endif
endinterface

// File: rtl/cell_pos_bank.sv
// cell_pos_bank: simple dual-port position RAM with registered address and registered output
module cell_pos_bank
  import cell_pos_pkg::*;
#(
  parameter int DATA_WIDTH = 3 * POS_WIDTH,
  parameter int DEPTH      = 220,
  parameter int AW         = 8
) (
  input  logic                  clock,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_addr;
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_addr  <= i_raddr;
    o_rdata <= r_mem[r_addr];
  end
endmodule

// File: rtl/cell_pos_pingpong.sv
// cell_pos_pingpong: double-buffered per-cell position store, one bank read while the other collects appends
// Optional overflow statistics are enabled with CELL_POS_OVERFLOW_EN.
module cell_pos_pingpong
  import cell_pos_pkg::*;
#(
  parameter int DATA_WIDTH = 3 * POS_WIDTH,
  parameter int DEPTH      = 220,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input logic               clock,
  input logic               rst_n,
  cell_pos_pingpong_if.slave bus
);
  localparam int BW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
  state_e                r_state;
  logic                  r_bank, r_busy, r_done;
  logic                  r_v1, r_v2, r_z1, r_z2, r_b1, r_b2;
  logic [CNT_WIDTH-1:0]  r_rd_count, r_wr_count;
  logic [DATA_WIDTH-1:0] w_q [2];
  logic                  w_full, w_rd_acc, w_wr_acc;
  assign w_full   = r_wr_count >= FULL;
  assign w_rd_acc = bus.rd_en && !r_busy;
  assign w_wr_acc = bus.wr_valid && !w_full && !r_busy;
  for (genvar g = 0; g < 2; g++) begin : g_bank
    cell_pos_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(BW)) u_bank (
      .clock   (clock),
      .i_we    (w_wr_acc && (r_bank != 1'(g))),
      .i_waddr (r_wr_count[BW-1:0]),
      .i_wdata (bus.wr_data),
      .i_raddr (bus.rd_addr[BW-1:0]),
      .o_rdata (w_q[g])
    );
  end
  // bank select and out-of-range flag travel with each read so a swap cannot disturb it
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_z1 <= 1'b0;
      r_z2 <= 1'b0;
      r_b1 <= 1'b0;
      r_b2 <= 1'b0;
    end else begin
      r_v1 <= w_rd_acc;
      r_v2 <= r_v1;
      r_z1 <= CNT_WIDTH'(bus.rd_addr) >= r_rd_count;
      r_z2 <= r_z1;
      r_b1 <= r_bank;
      r_b2 <= r_b1;
    end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bank     <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_acc) r_wr_count <= r_wr_count + 1'b1;
      case (r_state)
        ST_IDLE:  if (bus.swap_req) begin
          r_state <= ST_DRAIN;
          r_busy  <= 1'b1;
        end
        ST_DRAIN: if (!r_v1) r_state <= ST_SWAP;
        ST_SWAP:  begin
          r_state    <= ST_DONE;
          r_bank     <= ~r_bank;
          r_rd_count <= r_wr_count;
          r_wr_count <= '0;
          r_done     <= 1'b1;
        end
        ST_DONE:  begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  assign bus.rd_data   = (r_v2 && !r_z2) ? w_q[r_b2] : '0;
  assign bus.rd_valid  = r_v2;
  assign bus.rd_count  = r_rd_count;
  assign bus.wr_count  = r_wr_count;
  assign bus.wr_ready  = !w_full && !r_busy;
  assign bus.swap_busy = r_busy;
  assign bus.swap_done = r_done;
  assign bus.rd_bank   = r_bank;
`ifdef CELL_POS_OVERFLOW_EN
  logic        r_ovf_flag;
  logic [15:0] r_ovf_cnt;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      r_ovf_flag <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (r_state == ST_SWAP) begin
      r_ovf_flag <= 1'b0;
      r_ovf_cnt  <= '0;
    end else if (bus.wr_valid && w_full && !r_busy) begin
      r_ovf_flag <= 1'b1;
      r_ovf_cnt  <= r_ovf_cnt + 16'(r_ovf_cnt != 16'hFFFF);
    end
  assign bus.ovf_flag = r_ovf_flag;
  assign bus.ovf_cnt  = r_ovf_cnt;
`endif
endmodule

// File: tb/tb_cell_pos_pingpong.sv
// tb_cell_pos_pingpong: directed bench with a cycle-level behavioural model of the ping-pong store
module tb_cell_pos_pingpong;
  import cell_pos_pkg::*;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;
  always #5 clock = ~clock;
  cell_pos_pingpong_if #(.DATA_WIDTH(96), .ADDR_WIDTH(8), .CNT_WIDTH(9)) bus ();
  cell_pos_pingpong #(.DATA_WIDTH(96), .DEPTH(DEPTH), .ADDR_WIDTH(8), .CNT_WIDTH(9)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [95:0] mk(int n);
    return {32'(n + 200), 32'(n + 100), 32'(n)};
  endfunction
  // model state: bank contents, counts, pending read results and the cycle the swap completes
  logic [95:0] m_mem [2][DEPTH];
  int          m_rc, m_wc, m_req, m_done, cyc;
  bit          m_bank;
  bit          dv [4];
  logic [95:0] dd [4];
`ifdef CELL_POS_OVERFLOW_EN
  int          m_ovf;
  bit          m_ovff;
`endif
  task automatic mreset();
    m_rc = 0;
    m_wc = 0;
    m_bank = 1'b0;
    m_req = -1;
    m_done = -1;
    for (int i = 0; i < 4; i++) dv[i] = 1'b0;
`ifdef CELL_POS_OVERFLOW_EN
    m_ovf = 0;
    m_ovff = 1'b0;
`endif
  endtask
  initial begin : model
    bit b, ra;
    int s, t;
    mreset();
    cyc = 0;
    forever begin
      @(negedge clock);
      if (!rst_n) mreset();
      b = m_done >= 0 && cyc > m_req;
      s = cyc % 4;
      chk("rd_valid", bus.rd_valid, dv[s]);
      chk("rd_data", bus.rd_data, dv[s] ? dd[s] : 96'h0);
      chk("rd_count", bus.rd_count, m_rc);
      chk("wr_count", bus.wr_count, m_wc);
      chk("wr_ready", bus.wr_ready, m_wc < DEPTH && !b);
      chk("swap_busy", bus.swap_busy, b);
      chk("swap_done", bus.swap_done, cyc == m_done);
      chk("rd_bank", bus.rd_bank, m_bank);
`ifdef CELL_POS_OVERFLOW_EN
      chk("ovf_flag", bus.ovf_flag, m_ovff);
      chk("ovf_cnt", bus.ovf_cnt, m_ovf);
`endif
      if (rst_n) begin
        dv[s] = 1'b0;
        ra = bus.rd_en && !b;
        if (ra) begin
          t = (cyc + 2) % 4;
          dv[t] = 1'b1;
          dd[t] = int'(bus.rd_addr) < m_rc ? m_mem[m_bank][bus.rd_addr] : 96'h0;
        end
        if (bus.wr_valid && !b) begin
          if (m_wc < DEPTH) begin
            m_mem[!m_bank][m_wc] = bus.wr_data;
            m_wc++;
          end else begin
`ifdef CELL_POS_OVERFLOW_EN
            m_ovff = 1'b1;
            if (m_ovf < 65535) m_ovf++;
`endif
          end
        end
        // swap completes 3 cycles after the request, one more if a read was accepted with it
        if (bus.swap_req && m_done < 0) begin
          m_req = cyc;
          m_done = cyc + 3 + (ra ? 1 : 0);
        end else if (m_done >= 0 && cyc == m_done - 1) begin
          m_bank = !m_bank;
          m_rc = m_wc;
          m_wc = 0;
`ifdef CELL_POS_OVERFLOW_EN
          m_ovf = 0;
          m_ovff = 1'b0;
`endif
        end else if (cyc == m_done) m_done = -1;
      end
      cyc++;
    end
  end
  task automatic drv(bit re, int ra, bit wv, logic [95:0] wd, bit sr);
    bus.rd_en = re;
    bus.rd_addr = 8'(ra);
    bus.wr_valid = wv;
    bus.wr_data = wd;
    bus.swap_req = sr;
    @(posedge clock);
    #1;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 96'h0, 0);
  endtask
  initial begin : stim
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.swap_req = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    chk("lit reset rd_count", bus.rd_count, 0);
    chk("lit reset wr_ready", bus.wr_ready, 1);
    drv(1, 0, 0, 96'h0, 0);
    idle(1);
    chk("lit empty read valid", bus.rd_valid, 1);
    chk("lit empty read data", bus.rd_data, 96'h0);
    drv(0, 0, 1, mk(1), 0);
    drv(0, 0, 1, mk(2), 0);
    drv(0, 0, 1, mk(3), 0);
    chk("lit wr_count 3", bus.wr_count, 3);
    drv(0, 0, 0, 96'h0, 1);
    chk("lit busy after req", bus.swap_busy, 1);
    idle(2);
    chk("lit swap_done +3", bus.swap_done, 1);
    chk("lit rd_bank 1", bus.rd_bank, 1);
    chk("lit rd_count 3", bus.rd_count, 3);
    idle(1);
    drv(1, 0, 0, 96'h0, 0);
    drv(1, 1, 0, 96'h0, 0);
    chk("lit read0", bus.rd_data, 96'h000000c9_00000065_00000001);
    drv(1, 2, 0, 96'h0, 0);
    chk("lit read1", bus.rd_data, 96'h000000ca_00000066_00000002);
    drv(1, 3, 0, 96'h0, 0);
    chk("lit read2", bus.rd_data, 96'h000000cb_00000067_00000003);
    idle(1);
    chk("lit read3 valid", bus.rd_valid, 1);
    chk("lit read3 zero", bus.rd_data, 96'h0);
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 1, mk(10 + i), 0);
      if (i == 3) chk("lit full wr_ready", bus.wr_ready, 0);
    end
    chk("lit full wr_count", bus.wr_count, 4);
`ifdef CELL_POS_OVERFLOW_EN
    chk("lit ovf_flag", bus.ovf_flag, 1);
    chk("lit ovf_cnt", bus.ovf_cnt, 1);
`endif
    drv(0, 0, 0, 96'h0, 1);
    idle(2);
    chk("lit full rd_count", bus.rd_count, 4);
    idle(1);
    drv(1, 0, 0, 96'h0, 0);
    drv(1, 1, 0, 96'h0, 1);
    chk("lit old bank read0", bus.rd_data, 96'h000000d2_0000006e_0000000a);
    drv(1, 2, 0, 96'h0, 0);
    chk("lit old bank read1", bus.rd_data, 96'h000000d3_0000006f_0000000b);
    idle(1);
    chk("lit busy read ignored", bus.rd_valid, 0);
    chk("lit busy held", bus.swap_busy, 1);
    idle(1);
    chk("lit drained swap_done", bus.swap_done, 1);
    chk("lit empty swap rd_count", bus.rd_count, 0);
    idle(1);
    drv(0, 0, 1, mk(20), 0);
    drv(0, 0, 1, mk(21), 0);
    drv(0, 0, 1, mk(22), 1);
    drv(0, 0, 0, 96'h0, 1);
    idle(1);
    chk("lit simul swap_done", bus.swap_done, 1);
    chk("lit simul rd_count", bus.rd_count, 3);
    idle(3);
    drv(1, 2, 0, 96'h0, 0);
    idle(1);
    chk("lit simul read2", bus.rd_data, 96'h000000de_0000007a_00000016);
    drv(0, 0, 1, mk(30), 0);
    drv(1, 0, 0, 96'h0, 0);
    drv(1, 1, 0, 96'h0, 1);
    chk("lit pre-reset valid", bus.rd_valid, 1);
    chk("lit pre-reset data", bus.rd_data, 96'h000000dc_00000078_00000014);
    rst_n = 1'b0;
    #1;
    chk("lit async rd_valid", bus.rd_valid, 0);
    chk("lit async rd_data", bus.rd_data, 96'h0);
    chk("lit async swap_busy", bus.swap_busy, 0);
    chk("lit async rd_count", bus.rd_count, 0);
    chk("lit async wr_count", bus.wr_count, 0);
    @(posedge clock);
    #1 rst_n = 1'b1;
    drv(0, 0, 1, mk(40), 0);
    drv(0, 0, 0, 96'h0, 1);
    idle(2);
    chk("lit post-reset swap_done", bus.swap_done, 1);
    chk("lit post-reset rd_bank", bus.rd_bank, 1);
    chk("lit post-reset rd_count", bus.rd_count, 1);
    idle(1);
    drv(1, 0, 0, 96'h0, 0);
    idle(1);
    chk("lit post-reset read0", bus.rd_data, 96'h000000f0_0000008c_00000028);
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
